inst_trace_buffer: RTL and testbench
====================================

// Module: inst_trace_buffer
// PURPOSE
//  Debug trace capture downstream of the instruction ASCII decoder. Records each committed
//  instruction (PC, raw word, 40-bit ASCII mnemonic) into a circular buffer, stops on a PC
//  match or software trigger plus POST_TRIG further commits, then drains oldest-first over
//  a valid/ready port to the debug/UART side. Mnemonic string is stored as presented.
// PARAMETERS
//  DEPTH      8   entries held; power of 2, >=2; pointers are log2(DEPTH) bits
//  POST_TRIG  2   commits recorded after the trigger commit, 0..DEPTH-1
//  ASCII_W    40  mnemonic width (5 chars, space/zero padded by decoder)
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        asynchronous, active-high reset
//  commit_valid  in   1        one instruction retires this cycle
//  commit_pc     in   32       PC of retiring instruction
//  commit_instr  in   32       raw instruction word
//  commit_ascii  in   ASCII_W  decoder mnemonic for commit_instr
//  arm           in   1        pulse: clear buffer, start recording
//  trig_en       in   1        enable PC-match trigger
//  trig_pc       in   32       trigger PC
//  sw_trig       in   1        pulse: manual trigger
//  rd_valid      out  1        entry available on rd_*
//  rd_ready      in   1        consumer accepts entry
//  rd_pc         out  32       oldest entry PC
//  rd_instr      out  32       oldest entry instruction
//  rd_ascii      out  ASCII_W  oldest entry mnemonic
//  count         out  log2(DEPTH)+1  entries valid
//  state         out  2        00 IDLE, 01 RECORD, 10 POST, 11 DRAIN
//  overflow      out  1        sticky: an entry was overwritten since arm
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr/count/post_cnt 0, overflow 0, rd_valid 0; storage not cleared.
//  arm has top priority in any state: next cycle RECORD, wr_ptr=0, count=0, overflow=0;
//   a commit in the arm cycle is not captured.
//  IDLE: commits ignored; rd_valid 0.
//  RECORD: each commit_valid writes {pc,instr,ascii} at wr_ptr, wr_ptr++ mod DEPTH;
//   count++ saturating at DEPTH; write when count==DEPTH overwrites oldest, sets overflow.
//   Trigger = sw_trig | (trig_en & commit_valid & commit_pc==trig_pc); simultaneous
//   sources count as one trigger. Triggering commit is itself recorded. On trigger:
//   POST with post_cnt=POST_TRIG, or DRAIN directly if POST_TRIG==0.
//   sw_trig with no commit still triggers (no entry written).
//  POST: commits recorded as in RECORD; post_cnt-- per commit; commit with post_cnt==1
//   is written and state -> DRAIN. Further triggers ignored.
//  DRAIN: commits ignored. rd_valid = (count!=0). rd_* combinationally show entry at
//   rd_ptr = wr_ptr - count (mod DEPTH), i.e. oldest first. rd_valid&rd_ready: count--.
//   rd_* stable while rd_valid & !rd_ready. Pop taking count to 0 -> IDLE next cycle.
//  rd_valid is 0 outside DRAIN; rd_* undefined when rd_valid 0.
//  Zero latency read; one-cycle state update; 1 write and 1 pop per cycle maximum (they
//   never coincide since writes and pops occur in disjoint states).
//  Reset mid-operation (any state) returns to reset values immediately, no clock needed.
// TESTING  (DEPTH=8, POST_TRIG=2)
//  Reset asserted w/o clk -> state=00, rd_valid=0, count=0, overflow=0.
//  arm; commits PC 0x0,0x4..0x1C step 4, trig_en=1 trig_pc=0x14 -> DRAIN after 0x1C,
//   count=8, overflow=0; pops return PC 0x0..0x1C in order then state IDLE.
//  arm; commits 0x0..0x34 (14), trig_pc=0x2C -> holds 0x18..0x34, overflow=1, count=8.
//  In DRAIN hold rd_ready=0 3 cycles with commit_valid=1 -> rd_pc constant, count constant.
//  arm during POST -> next cycle state=01, count=0, overflow=0; same-cycle commit dropped.
//  sw_trig and PC match in same cycle -> single trigger, exactly 2 post commits recorded.

Source files
------------

// File: rtl/inst_trace_buffer_if.sv
// Trace-buffer bus: the commit stream coming in from the retire/decoder side,
// plus the valid/ready drain port going out to the debug/UART side.
//   master : drives the commit_* signals and rd_ready; observes rd_valid/rd_*
//   slave  : the trace buffer itself
interface inst_trace_buffer_if #(
    parameter int ASCII_W = 40
);
    logic               commit_valid;
    logic [31:0]        commit_pc;
    logic [31:0]        commit_instr;
    logic [ASCII_W-1:0] commit_ascii;

    logic               rd_valid;
    logic               rd_ready;
    logic [31:0]        rd_pc;
    logic [31:0]        rd_instr;
    logic [ASCII_W-1:0] rd_ascii;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_ascii, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_ascii
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_ascii, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_ascii
    );
endinterface

// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer. Records committed instructions {pc, instr, ascii}
// into a circular buffer after arm, stops on a PC-match or software trigger
// plus POST_TRIG further commits, then drains oldest-first over valid/ready.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          inst_trace_buffer_if.slave (commit stream in, drain port out);
//                its ASCII_W must match this module's ASCII_W
//   arm_i        pulse: clear buffer and start recording (beats everything)
//   trig_en_i    enable PC-match trigger against trig_pc_i
//   sw_trig_i    pulse: manual trigger
//   count_o      entries held
//   state_o      00 IDLE, 01 RECORD, 10 POST, 11 DRAIN
//   overflow_o   sticky: an entry was overwritten since arm
module inst_trace_buffer #(
    parameter int DEPTH     = 8,
    parameter int POST_TRIG = 2,
    parameter int ASCII_W   = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    inst_trace_buffer_if.slave       bus,
    input  logic                     arm_i,
    input  logic                     trig_en_i,
    input  logic [31:0]              trig_pc_i,
    input  logic                     sw_trig_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               state_o,
    output logic                     overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RECORD = 2'b01,
        S_POST   = 2'b10,
        S_DRAIN  = 2'b11
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   post_cnt_q;
    logic [PTR_W:0]     count_q;
    logic               overflow_q;

    logic [31:0]        mem_pc    [DEPTH];
    logic [31:0]        mem_instr [DEPTH];
    logic [ASCII_W-1:0] mem_ascii [DEPTH];

    logic               capturing;
    logic               wr_en;
    logic               pc_hit;
    logic               trig;
    logic               pop;
    logic [PTR_W-1:0]   rd_ptr;

    always_comb begin
        capturing = (state_q == S_RECORD) || (state_q == S_POST);
        // The arm cycle wins over any commit presented alongside it.
        wr_en     = capturing && bus.commit_valid && !arm_i;
        pc_hit    = trig_en_i && bus.commit_valid && (bus.commit_pc == trig_pc_i);
        // Only RECORD listens for triggers; both sources collapse into one event.
        trig      = (state_q == S_RECORD) && (sw_trig_i || pc_hit);
        // Oldest entry; when full, count's low bits are 0 so this lands on wr_ptr.
        rd_ptr    = wr_ptr_q - count_q[PTR_W-1:0];
    end

    assign bus.rd_valid = (state_q == S_DRAIN) && (count_q != '0);
    assign bus.rd_pc    = mem_pc[rd_ptr];
    assign bus.rd_instr = mem_instr[rd_ptr];
    assign bus.rd_ascii = mem_ascii[rd_ptr];
    assign pop          = bus.rd_valid && bus.rd_ready;

    assign count_o    = count_q;
    assign state_o    = state_q;
    assign overflow_o = overflow_q;

    // Storage is deliberately not reset; count_q qualifies what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]    <= bus.commit_pc;
            mem_instr[wr_ptr_q] <= bus.commit_instr;
            mem_ascii[wr_ptr_q] <= bus.commit_ascii;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (arm_i) begin
            state_q    <= S_RECORD;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_RECORD, S_POST: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (count_q == (PTR_W+1)'(DEPTH))
                            overflow_q <= 1'b1;
                        else
                            count_q <= count_q + (PTR_W+1)'(1);
                    end
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q    <= S_POST;
                            post_cnt_q <= PTR_W'(POST_TRIG);
                        end
                    end else if (state_q == S_POST && bus.commit_valid) begin
                        post_cnt_q <= post_cnt_q - PTR_W'(1);
                        if (post_cnt_q == PTR_W'(1))
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        count_q <= count_q - (PTR_W+1)'(1);
                        if (count_q == (PTR_W+1)'(1))
                            state_q <= S_IDLE;
                    end else if (count_q == '0) begin
                        // Trigger with nothing captured: nothing to drain.
                        state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_trace_buffer.sv
module tb_inst_trace_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        arm_i, trig_en_i, sw_trig_i;
    logic [31:0] trig_pc_i;
    logic [3:0]  count_o;
    logic [1:0]  state_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    inst_trace_buffer_if #(.ASCII_W(40)) bus();

    inst_trace_buffer #(.DEPTH(8), .POST_TRIG(2), .ASCII_W(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .arm_i      (arm_i),
        .trig_en_i  (trig_en_i),
        .trig_pc_i  (trig_pc_i),
        .sw_trig_i  (sw_trig_i),
        .count_o    (count_o),
        .state_o    (state_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [39:0] ascii_of(input logic [31:0] pc);
        return {16'h4144, pc[23:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_instr = instr_of(pc);
        bus.commit_ascii = ascii_of(pc);
        tick();
        bus.commit_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.rd_ready = 1'b1;
        while (state_o != 2'b00 && n < 40) begin
            tick();
            n++;
        end
        bus.rd_ready = 1'b0;
        chk("drain_idle", 64'(state_o), 64'd0);
        chk("drain_all_popped", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: every accepted entry must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got pc %0h want no entry", bus.rd_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.rd_pc !== e || bus.rd_instr !== instr_of(e) || bus.rd_ascii !== ascii_of(e)) begin
                    n_err++;
                    $display("FAIL pop_entry: got pc %0h instr %0h ascii %0h want pc %0h instr %0h ascii %0h",
                             bus.rd_pc, bus.rd_instr, bus.rd_ascii, e, instr_of(e), ascii_of(e));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        arm_i = 1'b0; trig_en_i = 1'b0; sw_trig_i = 1'b0; trig_pc_i = '0;
        bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_instr = '0;
        bus.commit_ascii = '0; bus.rd_ready = 1'b0;

        // Reset with no clock edge yet
        #2;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 8 commits, trigger on 0x14 -> exactly full, no overflow
        do_arm();
        trig_en_i = 1'b1;
        trig_pc_i = 32'h14;
        for (int i = 0; i < 8; i++) commit(32'(i * 4));
        chk("t1_state", 64'(state_o), 64'd3);
        chk("t1_count", 64'(count_o), 64'd8);
        chk("t1_overflow", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        drain();

        // 14 commits, trigger on 0x2C -> wraps, keeps 0x18..0x34
        do_arm();
        trig_pc_i = 32'h2C;
        for (int i = 0; i < 14; i++) commit(32'(i * 4));
        chk("t2_state", 64'(state_o), 64'd3);
        chk("t2_count", 64'(count_o), 64'd8);
        chk("t2_overflow", 64'(overflow_o), 64'd1);
        // Stall: consumer not ready, commits must be ignored
        for (int k = 0; k < 3; k++) begin
            bus.commit_valid = 1'b1;
            bus.commit_pc    = 32'h100;
            bus.commit_instr = instr_of(32'h100);
            bus.commit_ascii = ascii_of(32'h100);
            tick();
            chk("stall_rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("stall_rd_pc", 64'(bus.rd_pc), 64'h18);
            chk("stall_count", 64'(count_o), 64'd8);
        end
        bus.commit_valid = 1'b0;
        for (int i = 6; i < 14; i++) exp_q.push_back(32'(i * 4));
        drain();
        chk("t2_overflow_sticky", 64'(overflow_o), 64'd1);

        // arm during POST; commit in the arm cycle is dropped
        do_arm();
        chk("t3_overflow_cleared", 64'(overflow_o), 64'd0);
        trig_pc_i = 32'h40;
        commit(32'h40);
        commit(32'h44);
        chk("t3_in_post", 64'(state_o), 64'd2);
        arm_i = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_pc    = 32'h48;
        bus.commit_instr = instr_of(32'h48);
        bus.commit_ascii = ascii_of(32'h48);
        tick();
        arm_i = 1'b0;
        bus.commit_valid = 1'b0;
        chk("t3_rearm_state", 64'(state_o), 64'd1);
        chk("t3_rearm_count", 64'(count_o), 64'd0);
        chk("t3_rearm_overflow", 64'(overflow_o), 64'd0);

        // sw_trig and PC match together -> one trigger, two post commits
        trig_pc_i = 32'h58;
        commit(32'h50);
        commit(32'h54);
        sw_trig_i = 1'b1;
        commit(32'h58);
        sw_trig_i = 1'b0;
        chk("t4_post", 64'(state_o), 64'd2);
        commit(32'h5C);
        chk("t4_post1_state", 64'(state_o), 64'd2);
        chk("t4_post1_count", 64'(count_o), 64'd4);
        commit(32'h60);
        chk("t4_drain_state", 64'(state_o), 64'd3);
        chk("t4_drain_count", 64'(count_o), 64'd5);
        commit(32'h64);
        chk("t4_drain_ignores_commit", 64'(count_o), 64'd5);
        exp_q.push_back(32'h50); exp_q.push_back(32'h54); exp_q.push_back(32'h58);
        exp_q.push_back(32'h5C); exp_q.push_back(32'h60);
        drain();

        // sw_trig with no commit, then async reset mid-DRAIN
        do_arm();
        trig_en_i = 1'b0;
        sw_trig_i = 1'b1;
        tick();
        sw_trig_i = 1'b0;
        chk("t5_swtrig_state", 64'(state_o), 64'd2);
        chk("t5_swtrig_count", 64'(count_o), 64'd0);
        commit(32'h4);
        commit(32'h8);
        chk("t5_drain_state", 64'(state_o), 64'd3);
        chk("t5_drain_count", 64'(count_o), 64'd2);
        rst = 1'b1;
        #1;
        chk("t5_async_rst_state", 64'(state_o), 64'd0);
        chk("t5_async_rst_count", 64'(count_o), 64'd0);
        chk("t5_async_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
